ref_streamer: RTL and testbench

REF_STREAMER -- requirements
Module: ref_streamer

---
 rtl/knn_pkg.sv | 30 +++
 rtl/bit_interleaver.sv | 97 +++++++++
 rtl/ref_streamer.sv | 150 +++++++++++++++
 tb/tb_ref_streamer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types for the kNN reference streamer: coordinate width, dimension
// codes presented to the bit-distance unit, and controller states.
package knn_pkg;

    localparam int B = 32;

    typedef enum logic [1:0] {
        DIM_NONE = 2'b00,
        DIM_X    = 2'b01,
        DIM_Y    = 2'b10,
        DIM_Z    = 2'b11
    } dim_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_READY  = 2'b01,
        ST_STREAM = 2'b10,
        ST_WAIT   = 2'b11
    } state_e;

    // x -> y -> z -> x rotation; anything unexpected restarts at x
    function automatic dim_e dim_next(input dim_e d);
        case (d)
            DIM_X:   return DIM_Y;
            DIM_Y:   return DIM_Z;
            default: return DIM_X;
        endcase
    endfunction

endpackage

// File: rtl/bit_interleaver.sv
// Holds the query, plus working shift copies of query and reference, and
// emits one MSB-first bit per dimension in x,y,z rotation.
module bit_interleaver
    import knn_pkg::*;
#(
    parameter int B = knn_pkg::B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         q_load_i,
    input  logic [B-1:0] q_x_i,
    input  logic [B-1:0] q_y_i,
    input  logic [B-1:0] q_z_i,
    input  logic         r_load_i,
    input  logic [B-1:0] r_x_i,
    input  logic [B-1:0] r_y_i,
    input  logic [B-1:0] r_z_i,
    input  logic         adv_i,
    output logic         q_bit_o,
    output logic         r_bit_o,
    output dim_e         dim_o,
    output logic         dim_last_o
);

    logic [B-1:0] qx_q, qy_q, qz_q;
    logic [B-1:0] sqx_q, sqy_q, sqz_q;
    logic [B-1:0] srx_q, sry_q, srz_q;
    dim_e         dim_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            qx_q  <= '0;
            qy_q  <= '0;
            qz_q  <= '0;
            sqx_q <= '0;
            sqy_q <= '0;
            sqz_q <= '0;
            srx_q <= '0;
            sry_q <= '0;
            srz_q <= '0;
            dim_q <= DIM_X;
        end else begin
            if (q_load_i) begin
                qx_q <= q_x_i;
                qy_q <= q_y_i;
                qz_q <= q_z_i;
            end
            // The stored query stays intact so it can be replayed for every reference
            if (r_load_i) begin
                sqx_q <= qx_q;
                sqy_q <= qy_q;
                sqz_q <= qz_q;
                srx_q <= r_x_i;
                sry_q <= r_y_i;
                srz_q <= r_z_i;
                dim_q <= DIM_X;
            end else if (adv_i) begin
                dim_q <= dim_next(dim_q);
                if (dim_q == DIM_Z) begin
                    sqx_q <= {sqx_q[B-2:0], 1'b0};
                    sqy_q <= {sqy_q[B-2:0], 1'b0};
                    sqz_q <= {sqz_q[B-2:0], 1'b0};
                    srx_q <= {srx_q[B-2:0], 1'b0};
                    sry_q <= {sry_q[B-2:0], 1'b0};
                    srz_q <= {srz_q[B-2:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        q_bit_o = 1'b0;
        r_bit_o = 1'b0;
        case (dim_q)
            DIM_X: begin
                q_bit_o = sqx_q[B-1];
                r_bit_o = srx_q[B-1];
            end
            DIM_Y: begin
                q_bit_o = sqy_q[B-1];
                r_bit_o = sry_q[B-1];
            end
            DIM_Z: begin
                q_bit_o = sqz_q[B-1];
                r_bit_o = srz_q[B-1];
            end
            default: begin
                q_bit_o = 1'b0;
                r_bit_o = 1'b0;
            end
        endcase
    end

    assign dim_o      = dim_q;
    assign dim_last_o = (dim_q == DIM_Z);

endmodule

// File: rtl/ref_streamer.sv
// Streams query/reference coordinates bit-serially to a bit-distance unit and
// records whether each reference was kept or terminated early.
//   state  | meaning
//   IDLE   | no query loaded
//   READY  | query held, accepting a reference point
//   STREAM | emitting 3*B interleaved beats
//   WAIT   | all beats sent, awaiting done/terminate
module ref_streamer
    import knn_pkg::*;
#(
    parameter int B = knn_pkg::B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         q_load,
    input  logic [B-1:0] q_x,
    input  logic [B-1:0] q_y,
    input  logic [B-1:0] q_z,
    input  logic         ref_valid,
    output logic         ref_ready,
    input  logic [B-1:0] ref_x,
    input  logic [B-1:0] ref_y,
    input  logic [B-1:0] ref_z,
    input  logic [15:0]  ref_idx,
    output logic         bdu_valid,
    output logic         q_bit,
    output logic         r_bit,
    output logic [1:0]   code,
    output logic [5:0]   bit_pos,
    input  logic         terminate,
    input  logic         done,
    output logic         res_valid,
    output logic         res_kept,
    output logic [15:0]  res_idx,
    output logic [15:0]  n_kept,
    output logic [15:0]  n_term,
    output logic         busy
);

    localparam logic [6:0] LAST_BEAT = 7'(3 * B - 1);

    state_e       state_q, state_d;
    logic [6:0]   beat_q;
    logic [5:0]   bitpos_q;
    logic [15:0]  idx_q;
    logic         res_valid_q, res_kept_q;
    logic [15:0]  res_idx_q, n_kept_q, n_term_q;

    logic         streaming, hs, q_accept, term_ev, done_ev;
    logic         il_q_bit, il_r_bit, il_dim_last;
    dim_e         il_dim;

    assign streaming = (state_q == ST_STREAM);
    assign bdu_valid = streaming && !terminate && !done;
    assign hs        = (state_q == ST_READY) && ref_valid;
    assign q_accept  = q_load && ((state_q == ST_IDLE) || (state_q == ST_READY));
    assign term_ev   = terminate && ((state_q == ST_STREAM) || (state_q == ST_WAIT));
    assign done_ev   = done && !terminate && (state_q == ST_WAIT);

    bit_interleaver #(.B(B)) u_interleaver (
        .clk        (clk),
        .rst        (rst),
        .q_load_i   (q_accept),
        .q_x_i      (q_x),
        .q_y_i      (q_y),
        .q_z_i      (q_z),
        .r_load_i   (hs),
        .r_x_i      (ref_x),
        .r_y_i      (ref_y),
        .r_z_i      (ref_z),
        .adv_i      (bdu_valid),
        .q_bit_o    (il_q_bit),
        .r_bit_o    (il_r_bit),
        .dim_o      (il_dim),
        .dim_last_o (il_dim_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (q_load) state_d = ST_READY;
            end
            ST_READY: begin
                if (ref_valid) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (terminate) begin
                    state_d = ST_READY;
                end else if (bdu_valid && (beat_q == LAST_BEAT)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (terminate || done) state_d = ST_READY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_q      <= '0;
            bitpos_q    <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            res_kept_q  <= 1'b0;
            res_idx_q   <= '0;
            n_kept_q    <= '0;
            n_term_q    <= '0;
        end else begin
            res_valid_q <= term_ev || done_ev;
            res_kept_q  <= done_ev;
            if (term_ev || done_ev) res_idx_q <= idx_q;
            if (term_ev && (n_term_q != 16'hFFFF)) n_term_q <= n_term_q + 16'd1;
            if (done_ev && (n_kept_q != 16'hFFFF)) n_kept_q <= n_kept_q + 16'd1;

            if (hs) begin
                idx_q    <= ref_idx;
                beat_q   <= '0;
                bitpos_q <= 6'd1;
            end else if (bdu_valid) begin
                beat_q <= beat_q + 7'd1;
                // Bit position advances once per completed x,y,z triple
                if (il_dim_last) bitpos_q <= bitpos_q + 6'd1;
            end
        end
    end

    assign ref_ready = (state_q == ST_READY);
    assign busy      = (state_q == ST_STREAM) || (state_q == ST_WAIT);
    assign q_bit     = streaming ? il_q_bit : 1'b0;
    assign r_bit     = streaming ? il_r_bit : 1'b0;
    assign code      = streaming ? il_dim : 2'b00;
    assign bit_pos   = streaming ? bitpos_q : 6'd0;
    assign res_valid = res_valid_q;
    assign res_kept  = res_kept_q;
    assign res_idx   = res_idx_q;
    assign n_kept    = n_kept_q;
    assign n_term    = n_term_q;

endmodule

// File: tb/tb_ref_streamer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a beat-index model of the streamer.
module tb_ref_streamer;

    localparam int B = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         q_load;
    logic [B-1:0] q_x, q_y, q_z;
    logic         ref_valid;
    logic         ref_ready;
    logic [B-1:0] ref_x, ref_y, ref_z;
    logic [15:0]  ref_idx;
    logic         bdu_valid, q_bit, r_bit;
    logic [1:0]   code;
    logic [5:0]   bit_pos;
    logic         terminate, done;
    logic         res_valid, res_kept;
    logic [15:0]  res_idx, n_kept, n_term;
    logic         busy;

    always #5 clk = ~clk;

    ref_streamer #(.B(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_load    (q_load),
        .q_x       (q_x),
        .q_y       (q_y),
        .q_z       (q_z),
        .ref_valid (ref_valid),
        .ref_ready (ref_ready),
        .ref_x     (ref_x),
        .ref_y     (ref_y),
        .ref_z     (ref_z),
        .ref_idx   (ref_idx),
        .bdu_valid (bdu_valid),
        .q_bit     (q_bit),
        .r_bit     (r_bit),
        .code      (code),
        .bit_pos   (bit_pos),
        .terminate (terminate),
        .done      (done),
        .res_valid (res_valid),
        .res_kept  (res_kept),
        .res_idx   (res_idx),
        .n_kept    (n_kept),
        .n_term    (n_term),
        .busy      (busy)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=no query, 1=accepting, 2=streaming beat m_beat, 3=awaiting verdict
    int           m_mode = 0;
    int           m_beat = 0;
    logic [B-1:0] mq [3];
    logic [B-1:0] mr [3];
    int           m_idx = 0, m_kept = 0, m_term = 0;
    bit           m_rv = 0, m_rk = 0;
    int           m_ridx = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0; m_beat = 0; m_idx = 0;
            m_kept = 0; m_term = 0; m_rv = 0; m_rk = 0; m_ridx = 0;
            for (int d = 0; d < 3; d++) begin mq[d] = '0; mr[d] = '0; end
        end else begin
            m_rv = 0;
            m_rk = 0;
            case (m_mode)
                0: if (q_load) begin
                    mq[0] = q_x; mq[1] = q_y; mq[2] = q_z; m_mode = 1;
                end
                1: if (ref_valid) begin
                    mr[0] = ref_x; mr[1] = ref_y; mr[2] = ref_z;
                    m_idx = ref_idx; m_beat = 0; m_mode = 2;
                end else if (q_load) begin
                    mq[0] = q_x; mq[1] = q_y; mq[2] = q_z;
                end
                2: if (terminate) begin
                    m_rv = 1; m_ridx = m_idx; m_term = (m_term < 65535) ? m_term + 1 : m_term;
                    m_mode = 1;
                end else if (!done) begin
                    m_beat++;
                    if (m_beat == 3 * B) m_mode = 3;
                end
                default: if (terminate) begin
                    m_rv = 1; m_ridx = m_idx; m_term = (m_term < 65535) ? m_term + 1 : m_term;
                    m_mode = 1;
                end else if (done) begin
                    m_rv = 1; m_rk = 1; m_ridx = m_idx;
                    m_kept = (m_kept < 65535) ? m_kept + 1 : m_kept;
                    m_mode = 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int d, bi;
            logic eq, er;
            logic [1:0] ec;
            logic [5:0] ep;
            eq = 0; er = 0; ec = 0; ep = 0;
            if (m_mode == 2) begin
                d  = m_beat % 3;
                bi = B - 1 - m_beat / 3;
                eq = mq[d][bi];
                er = mr[d][bi];
                ec = 2'(d + 1);
                ep = 6'(m_beat / 3 + 1);
            end
            cmp("ref_ready", ref_ready, m_mode == 1);
            cmp("busy", busy, m_mode >= 2);
            cmp("bdu_valid", bdu_valid, (m_mode == 2) && !terminate && !done);
            cmp("q_bit", q_bit, eq);
            cmp("r_bit", r_bit, er);
            cmp("code", code, ec);
            cmp("bit_pos", bit_pos, ep);
            cmp("res_valid", res_valid, m_rv);
            if (m_rv) begin
                cmp("res_kept", res_kept, m_rk);
                cmp("res_idx", res_idx, m_ridx);
            end
            cmp("n_kept", n_kept, m_kept);
            cmp("n_term", n_term, m_term);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [15:0] idx);
        ref_x = $urandom; ref_y = $urandom; ref_z = $urandom;
        ref_idx = idx;
        ref_valid = 1'b1;
        step();
        ref_valid = 1'b0;
    endtask

    initial begin
        int nbeats;
        logic pq, pr;
        rst = 1'b0; q_load = 0; ref_valid = 0; terminate = 0; done = 0;
        q_x = 0; q_y = 0; q_z = 0; ref_x = 0; ref_y = 0; ref_z = 0; ref_idx = 0;
        repeat (3) step();
        chk_en = 1'b1;
        cmp("rst_ref_ready", ref_ready, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_bit_pos", bit_pos, 0);
        cmp("rst_n_kept", n_kept, 0);

        // ref_valid while no query is loaded
        rst = 1'b1;
        ref_valid = 1'b1; ref_x = 9;
        repeat (5) begin
            step();
            cmp("idle_ref_ready", ref_ready, 0);
            cmp("idle_bdu_valid", bdu_valid, 0);
        end
        ref_valid = 1'b0;

        // q=(5,0,0), ref=(4,0,0), idx 7 streamed to completion
        q_load = 1; q_x = 5; q_y = 0; q_z = 0;
        step();
        q_load = 0;
        cmp("ready_ref_ready", ref_ready, 1);
        ref_x = 4; ref_y = 0; ref_z = 0; ref_idx = 7; ref_valid = 1;
        step();
        ref_valid = 0;
        cmp("beat0_code", code, 1);
        cmp("beat0_bit_pos", bit_pos, 1);
        nbeats = 0; pq = 0; pr = 1;
        for (int i = 0; i < 96; i++) begin
            if (bdu_valid) nbeats++;
            if (bit_pos == 6'd32 && code == 2'b01) begin pq = q_bit; pr = r_bit; end
            step();
        end
        cmp("beat_count", nbeats, 96);
        cmp("lsb_x_q_bit", pq, 1);
        cmp("lsb_x_r_bit", pr, 0);
        cmp("wait_busy", busy, 1);
        cmp("wait_bdu_valid", bdu_valid, 0);
        step();
        done = 1;
        step();
        done = 0;
        cmp("kept_res_valid", res_valid, 1);
        cmp("kept_res_kept", res_kept, 1);
        cmp("kept_res_idx", res_idx, 7);
        cmp("kept_n_kept", n_kept, 1);

        // terminate on beat 10
        handshake(16'd3);
        repeat (10) step();
        terminate = 1;
        #1;
        cmp("term_bdu_valid", bdu_valid, 0);
        step();
        terminate = 0;
        cmp("term_res_valid", res_valid, 1);
        cmp("term_res_kept", res_kept, 0);
        cmp("term_n_term", n_term, 1);
        cmp("term_ref_ready", ref_ready, 1);
        cmp("term_res_idx", res_idx, 3);

        // q_load during STREAM must not disturb the bits
        handshake(16'd11);
        repeat (5) step();
        q_load = 1; q_x = '1; q_y = '1; q_z = '1;
        step();
        q_load = 0;
        repeat (90) step();
        cmp("qload_wait_busy", busy, 1);
        done = 1;
        step();
        done = 0;
        cmp("qload_n_kept", n_kept, 2);

        // reset at beat 50
        handshake(16'd20);
        repeat (50) step();
        rst = 0;
        step();
        rst = 1;
        cmp("midrst_busy", busy, 0);
        cmp("midrst_res_valid", res_valid, 0);
        cmp("midrst_code", code, 0);
        cmp("midrst_n_term", n_term, 0);
        cmp("midrst_res_idx", res_idx, 0);
        ref_valid = 1;
        repeat (3) begin
            step();
            cmp("midrst_ref_ready", ref_ready, 0);
        end
        ref_valid = 0;

        // terminate and done together in WAIT
        q_load = 1; q_x = $urandom; q_y = $urandom; q_z = $urandom;
        step();
        q_load = 0;
        handshake(16'd42);
        repeat (96) step();
        terminate = 1; done = 1;
        step();
        terminate = 0; done = 0;
        cmp("both_res_kept", res_kept, 0);
        cmp("both_n_term", n_term, 1);
        cmp("both_n_kept", n_kept, 0);

        // random traffic
        for (int c = 0; c < 6000; c++) begin
            rst       = ($urandom_range(0, 799) != 0);
            ref_valid = ($urandom_range(0, 3) == 0);
            q_load    = ($urandom_range(0, 7) == 0);
            if (m_mode == 1 && ref_valid) q_load = 0;
            q_x = $urandom; q_y = $urandom; q_z = $urandom;
            ref_x = $urandom; ref_y = $urandom; ref_z = $urandom;
            ref_idx   = 16'($urandom);
            terminate = ($urandom_range(0, 149) == 0);
            done      = (m_mode != 2) && ($urandom_range(0, 5) == 0);
            step();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
